// File: rtl/qam_pkg.sv
// Shared definitions for the 16-QAM symbol slicer: sample width, Gray levels,
// FSM state type and the per-channel decision helper.
package qam_pkg;

  localparam int DEMULT_W = 18;

  localparam logic [1:0] QAM_GRAY_NEG3 = 2'b00;
  localparam logic [1:0] QAM_GRAY_NEG1 = 2'b01;
  localparam logic [1:0] QAM_GRAY_POS1 = 2'b11;
  localparam logic [1:0] QAM_GRAY_POS3 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } slicer_state_t;

  // Maps the three threshold comparisons (>= +T, >= 0, >= -T) to a Gray level.
  function automatic logic [1:0] gray_level(input logic ge_pos,
                                            input logic ge_zero,
                                            input logic ge_neg);
    logic [1:0] lvl;
    if (ge_pos)       lvl = QAM_GRAY_POS3;
    else if (ge_zero) lvl = QAM_GRAY_POS1;
    else if (ge_neg)  lvl = QAM_GRAY_NEG1;
    else              lvl = QAM_GRAY_NEG3;
    return lvl;
  endfunction

endpackage

// File: rtl/qam_iad_chan.sv
// One integrate-and-dump channel: accumulates samples of a symbol and, on dump,
// registers the final sum together with its 2-bit Gray decision.
module qam_iad_chan
  import qam_pkg::*;
#(
  parameter int                      ACC_W  = 22,
  parameter logic signed [ACC_W-1:0] THRESH = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [DEMULT_W-1:0] sample,
  input  logic                       load,
  input  logic                       add,
  input  logic                       dump,
  output logic signed [ACC_W-1:0]    acc_out,
  output logic [1:0]                 bits
);

  localparam logic signed [ACC_W-1:0] NEG_THRESH = -THRESH;

  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_out_reg;
  logic [1:0]              bits_reg;
  logic                    ge_pos;
  logic                    ge_zero;
  logic                    ge_neg;

  assign sample_ext = ACC_W'(sample);
  assign sum        = acc_reg + sample_ext;

  // The decision is taken on the sum that includes the last sample of the symbol.
  assign ge_pos  = (sum >= THRESH);
  assign ge_zero = ~sum[ACC_W-1];
  assign ge_neg  = (sum >= NEG_THRESH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg     <= '0;
      acc_out_reg <= '0;
      bits_reg    <= 2'b00;
    end else begin
      if (load) begin
        acc_reg <= sample_ext;
      end else if (add || dump) begin
        acc_reg <= sum;
      end
      if (dump) begin
        acc_out_reg <= sum;
        bits_reg    <= gray_level(ge_pos, ge_zero, ge_neg);
      end
    end
  end

  assign acc_out = acc_out_reg;
  assign bits    = bits_reg;

endmodule

// File: rtl/qam_symbol_slicer.sv
// Integrate-and-dump matched filter plus 16-QAM hard slicer for demodulated I/Q
// products; the FSM tracks symbol alignment from sym_sync and flags realigns.
module qam_symbol_slicer
  import qam_pkg::*;
#(
  parameter  int SPS           = 16,
  parameter  int THRESH_SAMPLE = 8192,
  localparam int ACC_W         = DEMULT_W + $clog2(SPS)
) (
  input  logic                       axi_clk,
  input  logic                       axi_rstn,
  input  logic                       demult_valid,
  input  logic signed [DEMULT_W-1:0] demult_i,
  input  logic signed [DEMULT_W-1:0] demult_q,
  input  logic                       sym_sync,
  output logic                       sym_valid,
  output logic [3:0]                 sym_data,
  output logic signed [ACC_W-1:0]    acc_i,
  output logic signed [ACC_W-1:0]    acc_q,
  output logic                       align_err,
  output logic                       locked
);

  localparam int                      CNT_W    = $clog2(SPS);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(SPS - 1);
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic signed [ACC_W-1:0] THRESH   = ACC_W'(THRESH_SAMPLE * SPS);

  slicer_state_t    state_reg;
  slicer_state_t    state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             sym_valid_reg;
  logic             align_err_reg;
  logic             locked_reg;
  logic             load;
  logic             add;
  logic             dump;
  logic             realign;
  logic [1:0]       bits_i;
  logic [1:0]       bits_q;

  // Per-sample control decode; a sync on any non-first sample (including the
  // last one) restarts the symbol instead of dumping it.
  always_comb begin
    load       = 1'b0;
    add        = 1'b0;
    dump       = 1'b0;
    realign    = 1'b0;
    cnt_next   = cnt_reg;
    state_next = state_reg;
    if (demult_valid) begin
      case (state_reg)
        IDLE: begin
          if (sym_sync) begin
            load       = 1'b1;
            cnt_next   = CNT_ONE;
            state_next = RUN;
          end
        end
        RUN: begin
          if (sym_sync && (cnt_reg != '0)) begin
            load     = 1'b1;
            realign  = 1'b1;
            cnt_next = CNT_ONE;
          end else if (cnt_reg == '0) begin
            load     = 1'b1;
            cnt_next = CNT_ONE;
          end else if (cnt_reg == CNT_LAST) begin
            dump     = 1'b1;
            cnt_next = '0;
          end else begin
            add      = 1'b1;
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      sym_valid_reg <= 1'b0;
      align_err_reg <= 1'b0;
      locked_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      sym_valid_reg <= dump;
      align_err_reg <= realign;
      locked_reg    <= (state_next == RUN);
    end
  end

  qam_iad_chan #(
    .ACC_W (ACC_W),
    .THRESH(THRESH)
  ) u_chan_i (
    .clk    (axi_clk),
    .rst_n  (axi_rstn),
    .sample (demult_i),
    .load   (load),
    .add    (add),
    .dump   (dump),
    .acc_out(acc_i),
    .bits   (bits_i)
  );

  qam_iad_chan #(
    .ACC_W (ACC_W),
    .THRESH(THRESH)
  ) u_chan_q (
    .clk    (axi_clk),
    .rst_n  (axi_rstn),
    .sample (demult_q),
    .load   (load),
    .add    (add),
    .dump   (dump),
    .acc_out(acc_q),
    .bits   (bits_q)
  );

  assign sym_valid = sym_valid_reg;
  assign sym_data  = {bits_i, bits_q};
  assign align_err = align_err_reg;
  assign locked    = locked_reg;

endmodule

// File: tb/tb_qam_symbol_slicer.sv
// Self-checking bench for qam_symbol_slicer (SPS=4): a queue-based symbol model
// predicts dumps, decisions, realign pulses and lock state.
module tb_qam_symbol_slicer;

  localparam int SPS   = 4;
  localparam int TS    = 8192;
  localparam int ACC_W = 20;
  localparam int THR   = TS * SPS;

  logic                    axi_clk = 1'b0;
  logic                    axi_rstn = 1'b0;
  logic                    demult_valid = 1'b0;
  logic                    sym_sync = 1'b0;
  logic signed [17:0]      demult_i = '0;
  logic signed [17:0]      demult_q = '0;
  logic                    sym_valid;
  logic [3:0]              sym_data;
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;
  logic                    align_err;
  logic                    locked;

  qam_symbol_slicer #(.SPS(SPS), .THRESH_SAMPLE(TS)) dut (
    .axi_clk     (axi_clk),
    .axi_rstn    (axi_rstn),
    .demult_valid(demult_valid),
    .demult_i    (demult_i),
    .demult_q    (demult_q),
    .sym_sync    (sym_sync),
    .sym_valid   (sym_valid),
    .sym_data    (sym_data),
    .acc_i       (acc_i),
    .acc_q       (acc_q),
    .align_err   (align_err),
    .locked      (locked)
  );

  always #5 axi_clk = ~axi_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the samples of the symbol in progress, lock flag and the
  // expected (held) output values after the most recent clock edge.
  bit         m_locked = 1'b0;
  int         q_i[$];
  int         q_q[$];
  bit         exp_valid = 1'b0;
  bit         exp_align = 1'b0;
  int         exp_acc_i = 0;
  int         exp_acc_q = 0;
  logic [3:0] exp_data  = 4'b0000;

  function automatic logic [1:0] level(input int s);
    if (s >= THR)  return 2'b10;
    if (s >= 0)    return 2'b11;
    if (s >= -THR) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sum_of(input int q[$]);
    int s = 0;
    foreach (q[k]) s += q[k];
    return s;
  endfunction

  // One clock cycle of stimulus, then the model advances to match that edge.
  task automatic drive(input bit v, input int si, input int sq, input bit sync);
    @(negedge axi_clk);
    demult_valid = v;
    demult_i     = 18'(si);
    demult_q     = 18'(sq);
    sym_sync     = sync;
    @(posedge axi_clk);
    #1;
    demult_valid = 1'b0;
    sym_sync     = 1'b0;
    exp_valid    = 1'b0;
    exp_align    = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (sync) begin
          m_locked = 1'b1;
          q_i = {si};
          q_q = {sq};
        end
      end else if (sync && q_i.size() != 0) begin
        exp_align = 1'b1;
        q_i = {si};
        q_q = {sq};
      end else begin
        q_i.push_back(si);
        q_q.push_back(sq);
        if (q_i.size() == SPS) begin
          exp_valid = 1'b1;
          exp_acc_i = sum_of(q_i);
          exp_acc_q = sum_of(q_q);
          exp_data  = {level(exp_acc_i), level(exp_acc_q)};
          q_i.delete();
          q_q.delete();
          $display("symbol: acc_i=%0d acc_q=%0d sym_data=%b", exp_acc_i, exp_acc_q, exp_data);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 1'b0);
  endtask

  task automatic assert_reset();
    @(negedge axi_clk);
    axi_rstn = 1'b0;
    #1;
    m_locked  = 1'b0;
    q_i.delete();
    q_q.delete();
    exp_valid = 1'b0;
    exp_align = 1'b0;
    exp_acc_i = 0;
    exp_acc_q = 0;
    exp_data  = 4'b0000;
  endtask

  task automatic release_reset();
    @(negedge axi_clk);
    axi_rstn = 1'b1;
  endtask

  task automatic test_reset();
    assert_reset();
    total += 6;
    if (sym_valid !== 1'b0) begin bad++; $display("FAIL reset_sym_valid got=%b exp=0", sym_valid); end
    if (sym_data !== 4'b0000) begin bad++; $display("FAIL reset_sym_data got=%b exp=0000", sym_data); end
    if (acc_i !== '0) begin bad++; $display("FAIL reset_acc_i got=%0d exp=0", acc_i); end
    if (acc_q !== '0) begin bad++; $display("FAIL reset_acc_q got=%0d exp=0", acc_q); end
    if (align_err !== 1'b0) begin bad++; $display("FAIL reset_align_err got=%b exp=0", align_err); end
    if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
    release_reset();
  endtask

  task automatic test_basic();
    for (int k = 0; k < SPS; k++) begin
      drive(1'b1, 12288, -4096, k == 0);
      total++;
      if (sym_valid !== exp_valid) begin bad++; $display("FAIL basic_valid k=%0d got=%b exp=%b", k, sym_valid, exp_valid); end
    end
    total += 4;
    if (acc_i !== ACC_W'(49152)) begin bad++; $display("FAIL basic_acc_i got=%0d exp=49152", acc_i); end
    if (acc_q !== ACC_W'(-16384)) begin bad++; $display("FAIL basic_acc_q got=%0d exp=-16384", acc_q); end
    if (sym_data !== 4'b1001) begin bad++; $display("FAIL basic_sym_data got=%b exp=1001", sym_data); end
    if (locked !== 1'b1) begin bad++; $display("FAIL basic_locked got=%b exp=1", locked); end
    idle(1);
    total += 2;
    if (sym_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%b exp=0", sym_valid); end
    if (sym_data !== exp_data) begin bad++; $display("FAIL basic_hold got=%b exp=%b", sym_data, exp_data); end
  endtask

  task automatic test_thresholds();
    int vals[4] = '{8192, 0, -8192, -8193};
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < SPS; k++) drive(1'b1, vals[n], -vals[n], 1'b0);
      total += 3;
      if (sym_valid !== 1'b1) begin bad++; $display("FAIL thresh_valid v=%0d got=%b exp=1", vals[n], sym_valid); end
      if (sym_data !== exp_data) begin bad++; $display("FAIL thresh_data v=%0d got=%b exp=%b", vals[n], sym_data, exp_data); end
      if (acc_i !== ACC_W'(exp_acc_i)) begin bad++; $display("FAIL thresh_acc_i v=%0d got=%0d exp=%0d", vals[n], acc_i, exp_acc_i); end
    end
  endtask

  task automatic test_gaps();
    for (int k = 0; k < SPS; k++) begin
      drive(1'b1, 12288, -4096, k == 0);
      total++;
      if (sym_valid !== exp_valid) begin bad++; $display("FAIL gaps_valid k=%0d got=%b exp=%b", k, sym_valid, exp_valid); end
      if (k != SPS - 1) begin
        int g = $urandom_range(0, 5);
        for (int c = 0; c < g; c++) begin
          drive(1'b0, $urandom_range(0, 1000), 0, 1'b1);
          total++;
          if (sym_valid !== 1'b0) begin bad++; $display("FAIL gaps_idle got=%b exp=0", sym_valid); end
        end
      end
    end
    total += 3;
    if (acc_i !== ACC_W'(49152)) begin bad++; $display("FAIL gaps_acc_i got=%0d exp=49152", acc_i); end
    if (acc_q !== ACC_W'(-16384)) begin bad++; $display("FAIL gaps_acc_q got=%0d exp=-16384", acc_q); end
    if (sym_data !== 4'b1001) begin bad++; $display("FAIL gaps_sym_data got=%b exp=1001", sym_data); end
  endtask

  task automatic test_realign();
    int ivals[6] = '{100, 200, 300, 400, 500, 600};
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, ivals[k], -ivals[k], (k == 0) || (k == 2));
      total += 2;
      if (sym_valid !== exp_valid) begin bad++; $display("FAIL realign_valid k=%0d got=%b exp=%b", k, sym_valid, exp_valid); end
      if (align_err !== exp_align) begin bad++; $display("FAIL realign_err k=%0d got=%b exp=%b", k, align_err, exp_align); end
    end
    total += 2;
    if (acc_i !== ACC_W'(1800)) begin bad++; $display("FAIL realign_acc_i got=%0d exp=1800", acc_i); end
    if (exp_acc_i !== 1800) begin bad++; $display("FAIL realign_model got=%0d exp=1800", exp_acc_i); end
    idle(1);
    total++;
    if (align_err !== 1'b0) begin bad++; $display("FAIL realign_err_idle got=%b exp=0", align_err); end
  endtask

  task automatic test_prelock();
    assert_reset();
    release_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 20000, 20000, 1'b0);
      total += 2;
      if (sym_valid !== 1'b0) begin bad++; $display("FAIL prelock_valid k=%0d got=%b exp=0", k, sym_valid); end
      if (locked !== 1'b0) begin bad++; $display("FAIL prelock_locked k=%0d got=%b exp=0", k, locked); end
    end
    drive(1'b1, 1000, 1000, 1'b1);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL prelock_lock_rise got=%b exp=1", locked); end
    for (int k = 1; k < SPS; k++) drive(1'b1, 1000, 1000, 1'b0);
    total++;
    if (acc_i !== ACC_W'(exp_acc_i)) begin bad++; $display("FAIL prelock_acc_i got=%0d exp=%0d", acc_i, exp_acc_i); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 70000, -70000, 1'b0);
    drive(1'b1, 70000, -70000, 1'b0);
    assert_reset();
    total += 4;
    if (locked !== 1'b0) begin bad++; $display("FAIL rstmid_locked got=%b exp=0", locked); end
    if (acc_i !== '0) begin bad++; $display("FAIL rstmid_acc_i got=%0d exp=0", acc_i); end
    if (sym_data !== 4'b0000) begin bad++; $display("FAIL rstmid_sym_data got=%b exp=0000", sym_data); end
    if (sym_valid !== 1'b0) begin bad++; $display("FAIL rstmid_sym_valid got=%b exp=0", sym_valid); end
    release_reset();
    for (int k = 0; k < SPS; k++) begin
      drive(1'b1, -5000, 9000, k == 0);
      total++;
      if (sym_valid !== exp_valid) begin bad++; $display("FAIL rstmid_valid k=%0d got=%b exp=%b", k, sym_valid, exp_valid); end
    end
    total += 3;
    if (acc_i !== ACC_W'(-20000)) begin bad++; $display("FAIL rstmid_acc_i2 got=%0d exp=-20000", acc_i); end
    if (acc_q !== ACC_W'(36000)) begin bad++; $display("FAIL rstmid_acc_q2 got=%0d exp=36000", acc_q); end
    if (sym_data !== 4'b0110) begin bad++; $display("FAIL rstmid_sym_data2 got=%b exp=0110", sym_data); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      bit v  = ($urandom_range(0, 9) < 7);
      bit sy = ($urandom_range(0, 11) == 0);
      int si = int'($urandom_range(0, 262142)) - 131071;
      int sq = int'($urandom_range(0, 262142)) - 131071;
      drive(v, si, sq, sy);
      total += 6;
      if (sym_valid !== exp_valid) begin bad++; $display("FAIL rand_valid k=%0d got=%b exp=%b", k, sym_valid, exp_valid); end
      if (align_err !== exp_align) begin bad++; $display("FAIL rand_align k=%0d got=%b exp=%b", k, align_err, exp_align); end
      if (locked !== m_locked) begin bad++; $display("FAIL rand_locked k=%0d got=%b exp=%b", k, locked, m_locked); end
      if (acc_i !== ACC_W'(exp_acc_i)) begin bad++; $display("FAIL rand_acc_i k=%0d got=%0d exp=%0d", k, acc_i, exp_acc_i); end
      if (acc_q !== ACC_W'(exp_acc_q)) begin bad++; $display("FAIL rand_acc_q k=%0d got=%0d exp=%0d", k, acc_q, exp_acc_q); end
      if (sym_data !== exp_data) begin bad++; $display("FAIL rand_data k=%0d got=%b exp=%b", k, sym_data, exp_data); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_thresholds();
    test_gaps();
    test_realign();
    test_prelock();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qam_symbol_slicer.md
# qam_symbol_slicer

Downstream neighbour of the QAM demultiplier. It consumes the demodulated baseband I/Q products (5Q12, 18-bit, with a valid strobe). It integrates each channel over one symbol period (integrate-and-dump matched filter), then slices the two sums into a Gray-coded 16-QAM symbol. Its outputs are the 4-bit hard decision and the soft accumulator values, which feed the bit unpacker and the error monitor.

## Interface
Parameters:
- SPS, 16: samples per symbol; legal range 2..64, power of two not required.
- THRESH_SAMPLE, 8192: decision threshold per sample in 5Q12 units (2.0); effective threshold THRESH = THRESH_SAMPLE*SPS.
- ACC_W, 18+$clog2(SPS): accumulator width (derived, not overridden).

Ports:
- axi_clk  in  1  single clock for the block.
- axi_rstn  in  1  reset; asynchronous, active-low.
- demult_valid  in  1  input sample strobe; may deassert for any number of cycles.
- demult_i  in  18  signed I product, 5Q12.
- demult_q  in  18  signed Q product, 5Q12.
- sym_sync  in  1  pulse marking the first sample of a symbol; sampled only when demult_valid=1.
- sym_valid  out  1  one-cycle strobe, decision available.
- sym_data  out  4  {I bits[1:0], Q bits[1:0]}, Gray coded.
- acc_i  out  ACC_W  signed soft I sum of the symbol.
- acc_q  out  ACC_W  signed soft Q sum of the symbol.
- align_err  out  1  one-cycle pulse, sym_sync arrived mid-symbol.
- locked  out  1  high while FSM in RUN.

## Operation
- FSM states IDLE, RUN. Reset → IDLE.
- IDLE: samples discarded. A valid sample with sym_sync=1 → RUN; that sample is loaded as sample 0 and cnt is set to 1.
- RUN: each valid sample does the following:
  - If cnt==0, load: acc<=sample, sign-extended.
  - Otherwise accumulate: acc<=acc+sample.
  - cnt increments; on the SPS-th sample (cnt==SPS-1), cnt wraps to 0 and a dump is issued.
- Dump: the registered outputs capture the final sum (acc plus the last sample), and sym_valid pulses.
- Slicing per channel on sum s, signed compare:
  - s >= THRESH → 2'b10
  - 0 <= s < THRESH → 2'b11
  - −THRESH <= s < 0 → 2'b01
  - s < −THRESH → 2'b00
- sym_sync in RUN with cnt==0: normal, no effect.
- sym_sync in RUN with cnt!=0:
  - The partial symbol is discarded, with no sym_valid.
  - align_err pulses.
  - The current sample is loaded as sample 0 and cnt is set to 1.
- sym_sync on the SPS-th sample counts as a realign: the partial symbol is discarded, not dumped.
- Arithmetic: ACC_W guarantees no overflow (|sample| < 2^17, SPS terms). No saturation logic is needed. THRESH is computed at elaboration with width ACC_W.
- demult_valid=0: state, cnt and acc hold.

## Timing
- Latency: sym_valid, sym_data, acc_i and acc_q assert on the cycle after the clock edge that accepted the SPS-th sample. sym_valid is high for exactly one cycle.
- sym_data, acc_i and acc_q hold their values until the next dump.
- align_err asserts on the cycle after the offending sample and lasts one cycle.
- locked asserts on the cycle after the first sym_sync is accepted.
- Minimum symbol spacing is SPS cycles. Back-to-back symbols with continuous valid produce sym_valid every SPS cycles.
- Reset values: sym_valid=0, sym_data=4'b0000, acc_i=0, acc_q=0, align_err=0, locked=0. cnt and the internal acc are also 0.
- Reset asserted mid-symbol: immediate return to IDLE and the partial sum is lost. After release, the block waits for sym_sync.

## Structure
- Shared package qam_pkg holds:
  - the Gray map constants (QAM_GRAY_NEG3=2'b00, NEG1=2'b01, POS1=2'b11, POS3=2'b10);
  - the 5Q12 width constant (DEMULT_W=18);
  - the FSM state enum.
- Sub-module qam_iad_chan, instantiated twice (I and Q), contains the accumulator plus slicer and takes load/add/dump controls.
- The top level holds the FSM, cnt and the alignment logic.

## Test plan
- SPS=4, THRESH_SAMPLE=8192. sym_sync plus 4 continuous samples with I=12288 and Q=−4096 → one cycle later: acc_i=49152, acc_q=−16384, sym_data=4'b1001, sym_valid for one cycle.
- Threshold boundaries over 4-sample symbols (THRESH=32768): I=8192 → 10; I=0 → 11; I=−8192 → 01; I=−8193 → 00.
- Same stimulus as the first test with demult_valid gaps of 0–5 random cycles between samples → identical outputs. sym_valid comes one cycle after the 4th valid sample.
- sym_sync reasserted on the 3rd sample of a symbol → no sym_valid for the partial symbol, and align_err pulses. The next dump occurs after 4 valid samples counted from the realign sample.
- Valid samples before any sym_sync → no sym_valid and locked=0. locked rises the cycle after the first sym_sync.
- axi_rstn pulsed low after 2 samples → all outputs 0 immediately and the FSM returns to IDLE. After release, a new sync plus 4 samples gives a correct symbol with no contribution from the earlier samples.
